// File: rtl/mux2_rr_arbiter.sv
// Two-input round-robin arbiter feeding a one-entry output register.
// S carries the index of the source whose beat currently sits in the register.
module mux2_rr_arbiter #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I0_data,
    input  logic             I0_valid,
    output logic             I0_ready,
    input  logic [WIDTH-1:0] I1_data,
    input  logic             I1_valid,
    output logic             I1_ready,
    output logic [WIDTH-1:0] O_data,
    output logic             O_valid,
    input  logic             O_ready,
    output logic             S
);

    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q,  o_data_d;
    logic             s_q,       s_d;
    logic             last_q,    last_d;

    logic load;
    logic grant_any;
    logic grant_idx;
    logic accept;

    assign load      = !o_valid_q || O_ready;
    assign grant_any = I0_valid || I1_valid;
    // On a tie the source that did not win last time goes first.
    assign grant_idx = (I0_valid && I1_valid) ? !last_q : I1_valid;

    assign I0_ready = load && grant_any && !grant_idx && !RESET;
    assign I1_ready = load && grant_any &&  grant_idx && !RESET;
    assign accept   = I0_ready || I1_ready;

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        s_d       = s_q;
        last_d    = last_q;
        if (load) begin
            if (accept) begin
                o_valid_d = 1'b1;
                o_data_d  = grant_idx ? I1_data : I0_data;
                s_d       = grant_idx;
                last_d    = grant_idx;
            end else begin
                o_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            s_q       <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            s_q       <= s_d;
            last_q    <= last_d;
        end
    end

    assign O_valid = o_valid_q;
    assign O_data  = o_data_q;
    assign S       = s_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter (WIDTH=4): reset, contention, lone requester,
// backpressure, mid-stream reset and drain, with hand-computed expectations.
module tb_mux2_rr_arbiter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] i0_data, i1_data, o_data;
    logic             i0_valid, i1_valid, i0_ready, i1_ready;
    logic             o_valid, o_ready, s;

    int checks = 0;
    int errors = 0;

    mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .I0_data  (i0_data),
        .I0_valid (i0_valid),
        .I0_ready (i0_ready),
        .I1_data  (i1_data),
        .I1_valid (i1_valid),
        .I1_ready (i1_ready),
        .O_data   (o_data),
        .O_valid  (o_valid),
        .O_ready  (o_ready),
        .S        (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check readies mid-cycle, then registered outputs after the edge.
    task automatic step(input string tag, input logic r0, input logic r1,
                        input logic ov, input logic [WIDTH-1:0] od, input logic es,
                        input logic chk_data);
        #1;
        chk({tag, ".I0_ready"}, {31'd0, i0_ready}, {31'd0, r0});
        chk({tag, ".I1_ready"}, {31'd0, i1_ready}, {31'd0, r1});
        @(posedge clk);
        #1;
        chk({tag, ".O_valid"}, {31'd0, o_valid}, {31'd0, ov});
        if (chk_data) begin
            chk({tag, ".O_data"}, {28'd0, o_data}, {28'd0, od});
            chk({tag, ".S"}, {31'd0, s}, {31'd0, es});
        end
        $display("step %-10s r0=%0b r1=%0b O_valid=%0b O_data=%0h S=%0b",
                 tag, i0_ready, i1_ready, o_valid, o_data, s);
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        i0_valid = 1'b1;
        i1_valid = 1'b1;
        i0_data  = 4'hA;
        i1_data  = 4'h5;
        o_ready  = 1'b1;
        @(negedge clk);

        // Reset held two cycles with both sources requesting.
        step("rst0", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        step("rst1", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

        // Contention: strict alternation starting with I0.
        rst = 1'b0;
        step("cont0", 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1);
        step("cont1", 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1);
        step("cont2", 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1);
        step("cont3", 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1);

        // Lone requester I1 served every cycle.
        i0_valid = 1'b0;
        i1_data  = 4'h3;
        for (int k = 0; k < 4; k++)
            step("lone", 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1);
        i0_valid = 1'b1;
        step("lone_tie", 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1);

        // Load 0x5 from I1, then stall.
        i1_data = 4'h5;
        step("bp_load", 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1);
        o_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            step("bp_hold", 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b1);
        o_ready = 1'b1;
        step("bp_rel", 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1);

        // Mid-stream reset with last=0; post-reset tie must go to I0.
        rst = 1'b1;
        step("mid_rst", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        rst = 1'b0;
        step("post_rst", 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1);

        // Drain: one beat from I0, then no requests.
        i1_valid = 1'b0;
        i0_data  = 4'h7;
        step("drain_ld", 1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 1'b1);
        i0_valid = 1'b0;
        step("drain0", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        step("drain1", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
